// File: rtl/jtframe_mr_pkg.sv
// Shared types and constants for the MiSTer HPS upload (read-back) path.
package jtframe_mr_pkg;

    // Upload sequencer states; GAP and FETCH_HI are only visited in 16-bit mode.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_LO = 2'd1,
        GAP      = 2'd2,
        FETCH_HI = 2'd3
    } mr_state_t;

    // File index served by default (NVRAM / high-score slot).
    localparam logic [7:0] MR_UPLOAD_INDEX = 8'd2;

    // Value returned for bytes beyond the end of the memory image.
    localparam logic [7:0] MR_FILL = 8'hFF;

endpackage

// File: rtl/jtframe_mr_bytefetch.sv
// Single-byte read from the core memory port. A start pulse latches the
// address; in-range bytes perform a mem_rd/mem_ok handshake, out-of-range
// bytes complete on the following cycle with the fill value and no mem_rd.
module jtframe_mr_bytefetch
    import jtframe_mr_pkg::*;
#(
    parameter int AW   = 16,
    parameter int SIZE = 65536
)(
    input  logic          clk_sys,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [26:0]   addr,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_dout,
    input  logic          mem_ok,
    output logic          done,
    output logic [7:0]    data
);

    localparam logic [31:0] SIZE_W = 32'(SIZE);

    logic          busy_reg;
    logic          oor_reg;
    logic          rd_reg;
    logic [AW-1:0] addr_reg;
    logic          in_range;

    // Range check uses the full request address, not the truncated one.
    assign in_range = ({5'd0, addr} < SIZE_W);

    // mem_ok is only meaningful while our own read strobe is up.
    assign done = busy_reg && (oor_reg || (rd_reg && mem_ok));
    assign data = oor_reg ? MR_FILL : mem_dout;

    assign mem_addr = addr_reg;
    assign mem_rd   = rd_reg;

    // Handshake register: address is held steady for the whole strobe.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            busy_reg <= 1'b0;
            oor_reg  <= 1'b0;
            rd_reg   <= 1'b0;
            addr_reg <= '0;
        end else if (abort) begin
            busy_reg <= 1'b0;
            rd_reg   <= 1'b0;
        end else if (start) begin
            busy_reg <= 1'b1;
            oor_reg  <= ~in_range;
            rd_reg   <= in_range;
            addr_reg <= addr[AW-1:0];
        end else if (done) begin
            busy_reg <= 1'b0;
            rd_reg   <= 1'b0;
        end
    end

endmodule

// File: rtl/jtframe_mr_upload.sv
// Answers hps_io upload reads by fetching bytes from core memory. In 16-bit
// mode two consecutive bytes are packed with the even byte in bits [7:0].
module jtframe_mr_upload
    import jtframe_mr_pkg::*;
#(
    parameter int         WIDE         = 0,
    parameter int         AW           = 16,
    parameter int         SIZE         = 65536,
    parameter logic [7:0] UPLOAD_INDEX = MR_UPLOAD_INDEX
)(
    input  logic                                 clk_sys,
    input  logic                                 rst,
    input  logic                                 ioctl_upload,
    input  logic [7:0]                           ioctl_index,
    input  logic                                 ioctl_rd,
    input  logic [26:0]                          ioctl_addr,
    output logic [((WIDE != 0) ? 16 : 8)-1:0]    ioctl_din,
    output logic                                 ioctl_wait,
    output logic                                 mem_sel,
    output logic [AW-1:0]                        mem_addr,
    output logic                                 mem_rd,
    input  logic [7:0]                           mem_dout,
    input  logic                                 mem_ok
);

    localparam int DW = (WIDE != 0) ? 16 : 8;

    mr_state_t     state_reg, state_next;
    logic [DW-1:0] din_reg, din_next;
    logic          wait_reg, wait_next;
    logic [7:0]    lo_reg, lo_next;
    logic [26:0]   base_reg, base_next;
    logic          sel_reg;
    logic          active;

    logic          fetch_start;
    logic          fetch_abort;
    logic          fetch_done;
    logic [26:0]   fetch_addr;
    logic [7:0]    fetch_data;
    logic [DW-1:0] word_lo;
    logic [DW-1:0] word_hi;

    assign active = ioctl_upload && (ioctl_index == UPLOAD_INDEX);

    assign ioctl_din  = din_reg;
    assign ioctl_wait = wait_reg;
    assign mem_sel    = sel_reg;

    // Word assembly for the two completion points of the sequencer.
    generate
        if (WIDE != 0) begin : g_wide
            assign word_lo = {8'h00, fetch_data};
            assign word_hi = {fetch_data, lo_reg};
        end else begin : g_narrow
            // FETCH_HI is never reached in 8-bit mode.
            assign word_lo = fetch_data;
            assign word_hi = lo_reg;
        end
    endgenerate

    jtframe_mr_bytefetch #(
        .AW   (AW),
        .SIZE (SIZE)
    ) u_fetch (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .start    (fetch_start),
        .abort    (fetch_abort),
        .addr     (fetch_addr),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_dout (mem_dout),
        .mem_ok   (mem_ok),
        .done     (fetch_done),
        .data     (fetch_data)
    );

    // Next-state logic: losing the active session cancels any fetch in flight.
    always_comb begin
        state_next  = state_reg;
        din_next    = din_reg;
        wait_next   = wait_reg;
        lo_next     = lo_reg;
        base_next   = base_reg;
        fetch_start = 1'b0;
        fetch_abort = 1'b0;
        fetch_addr  = ioctl_addr;
        if ((state_reg != IDLE) && !active) begin
            fetch_abort = 1'b1;
            wait_next   = 1'b0;
            state_next  = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ioctl_rd && active) begin
                        fetch_start = 1'b1;
                        base_next   = ioctl_addr;
                        wait_next   = 1'b1;
                        state_next  = FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    if (fetch_done) begin
                        lo_next = fetch_data;
                        if (WIDE != 0) begin
                            state_next = GAP;
                        end else begin
                            din_next   = word_lo;
                            wait_next  = 1'b0;
                            state_next = IDLE;
                        end
                    end
                end
                GAP: begin
                    fetch_start = 1'b1;
                    fetch_addr  = base_reg + 27'd1;
                    state_next  = FETCH_HI;
                end
                FETCH_HI: begin
                    if (fetch_done) begin
                        din_next   = word_hi;
                        wait_next  = 1'b0;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State and output registers; mem_sel follows the session condition by one cycle.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            din_reg   <= '0;
            wait_reg  <= 1'b0;
            lo_reg    <= 8'h00;
            base_reg  <= '0;
            sel_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            din_reg   <= din_next;
            wait_reg  <= wait_next;
            lo_reg    <= lo_next;
            base_reg  <= base_next;
            sel_reg   <= active;
        end
    end

endmodule

// File: tb/tb_jtframe_mr_upload.sv
// Bench for jtframe_mr_upload: an 8-bit instance (SIZE=0x100) and a 16-bit
// instance (SIZE=0xFF) share the hps_io stimulus, each with its own memory.
module tb_jtframe_mr_upload;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ioctl_upload = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_rd = 1'b0;
    logic [26:0] ioctl_addr = '0;

    logic [7:0]  din8;
    logic        wait8, sel8, rd8, ok8;
    logic [15:0] addr8;
    logic [7:0]  dout8;

    logic [15:0] din16;
    logic        wait16, sel16, rd16, ok16;
    logic [15:0] addr16;
    logic [7:0]  dout16;

    logic [7:0]  mem8  [0:255];
    logic [7:0]  mem16 [0:255];
    int          delay8 = 1, delay16 = 1;
    int          cnt8 = 0, cnt16 = 0;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  exp8_q[$];
    logic [15:0] exp16_q[$];

    logic        prev_wait8 = 0, prev_wait16 = 0, prev_rd8 = 0, prev_rd16 = 0;
    int          dur8_cnt = 0, dur16_cnt = 0, dur8_last = 0, dur16_last = 0;
    int          rise8 = 0, rise16 = 0, low16 = 0, gap16_last = 0;
    logic [15:0] rd_addr8 = '0, rd_addr16 = '0;
    logic        moved8 = 0, moved16 = 0;

    always #5 clk = ~clk;

    jtframe_mr_upload #(.WIDE(0), .AW(16), .SIZE(32'h100), .UPLOAD_INDEX(8'd2)) dut8 (
        .clk_sys(clk), .rst(rst), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
        .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(din8), .ioctl_wait(wait8),
        .mem_sel(sel8), .mem_addr(addr8), .mem_rd(rd8), .mem_dout(dout8), .mem_ok(ok8));

    jtframe_mr_upload #(.WIDE(1), .AW(16), .SIZE(32'hFF), .UPLOAD_INDEX(8'd2)) dut16 (
        .clk_sys(clk), .rst(rst), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
        .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(din16), .ioctl_wait(wait16),
        .mem_sel(sel16), .mem_addr(addr16), .mem_rd(rd16), .mem_dout(dout16), .mem_ok(ok16));

    // Memory model for the 8-bit instance: mem_ok delay8 cycles after mem_rd is seen.
    always @(posedge clk) begin
        if (rst) begin
            cnt8 <= 0; ok8 <= 1'b0; dout8 <= 8'h00;
        end else begin
            ok8 <= 1'b0;
            if (rd8 && !ok8) begin
                if (cnt8 + 1 >= delay8) begin
                    ok8 <= 1'b1; dout8 <= mem8[addr8[7:0]]; cnt8 <= 0;
                end else cnt8 <= cnt8 + 1;
            end else cnt8 <= 0;
        end
    end

    // Memory model for the 16-bit instance.
    always @(posedge clk) begin
        if (rst) begin
            cnt16 <= 0; ok16 <= 1'b0; dout16 <= 8'h00;
        end else begin
            ok16 <= 1'b0;
            if (rd16 && !ok16) begin
                if (cnt16 + 1 >= delay16) begin
                    ok16 <= 1'b1; dout16 <= mem16[addr16[7:0]]; cnt16 <= 0;
                end else cnt16 <= cnt16 + 1;
            end else cnt16 <= 0;
        end
    end

    // Observation at each falling edge: scoreboard pops on ioctl_wait falling.
    task automatic sample();
        logic [7:0]  e8;
        logic [15:0] e16;
        if (prev_wait8 && !wait8) begin
            checks++;
            if (exp8_q.size() == 0) begin
                errors++; $display("FAIL sb8_unexpected: wait fell with din=%h, nothing queued", din8);
            end else begin
                e8 = exp8_q.pop_front();
                if (din8 !== e8) begin errors++; $display("FAIL sb8_din: got %h expected %h", din8, e8); end
                else $display("txn dut8  din=%h wait_cycles=%0d", din8, dur8_cnt);
            end
            dur8_last = dur8_cnt;
        end
        dur8_cnt   = wait8 ? dur8_cnt + 1 : 0;
        prev_wait8 = wait8;
        if (prev_wait16 && !wait16) begin
            checks++;
            if (exp16_q.size() == 0) begin
                errors++; $display("FAIL sb16_unexpected: wait fell with din=%h, nothing queued", din16);
            end else begin
                e16 = exp16_q.pop_front();
                if (din16 !== e16) begin errors++; $display("FAIL sb16_din: got %h expected %h", din16, e16); end
                else $display("txn dut16 din=%h wait_cycles=%0d", din16, dur16_cnt);
            end
            dur16_last = dur16_cnt;
        end
        dur16_cnt   = wait16 ? dur16_cnt + 1 : 0;
        prev_wait16 = wait16;
        if (rd8 && !prev_rd8) begin rise8++; rd_addr8 = addr8; end
        if (rd8 && (addr8 !== rd_addr8)) moved8 = 1'b1;
        prev_rd8 = rd8;
        if (rd16 && !prev_rd16) begin rise16++; rd_addr16 = addr16; gap16_last = low16; end
        if (rd16 && (addr16 !== rd_addr16)) moved16 = 1'b1;
        low16     = rd16 ? 0 : low16 + 1;
        prev_rd16 = rd16;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
    endtask

    // One-cycle ioctl_rd; expected words come from the bench's own memory images.
    task automatic request(input logic [26:0] a, input bit p8, input bit p16);
        logic [26:0] a1;
        logic [7:0]  lo, hi;
        a1 = a + 27'd1;
        lo = (a  < 27'hFF) ? mem16[a[7:0]]  : 8'hFF;
        hi = (a1 < 27'hFF) ? mem16[a1[7:0]] : 8'hFF;
        if (p8)  exp8_q.push_back((a < 27'h100) ? mem8[a[7:0]] : 8'hFF);
        if (p16) exp16_q.push_back({hi, lo});
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd   = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((wait8 || wait16 || exp8_q.size() != 0 || exp16_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL timeout: pending8=%0d pending16=%0d expected 0", exp8_q.size(), exp16_q.size());
            exp8_q.delete();
            exp16_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (din8 !== 8'h00) begin errors++; $display("FAIL rst_din8: got %h expected 00", din8); end
        checks++; if (din16 !== 16'h0000) begin errors++; $display("FAIL rst_din16: got %h expected 0000", din16); end
        checks++; if ({wait8, wait16, sel8, sel16, rd8, rd16} !== 6'b0) begin
            errors++; $display("FAIL rst_ctrl: got %b expected 000000", {wait8, wait16, sel8, sel16, rd8, rd16}); end
        checks++; if ({addr8, addr16} !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", {addr8, addr16}); end
        rst = 1'b0;
        ioctl_upload = 1'b1;
        ioctl_index  = 8'd2;
        #1;
        checks++; if (sel8 !== 1'b0) begin errors++; $display("FAIL sel_early: got %b expected 0", sel8); end
        tick();
        checks++; if ({sel8, sel16} !== 2'b11) begin errors++; $display("FAIL sel_rise: got %b expected 11", {sel8, sel16}); end
    endtask

    task automatic test_byte8();
        int r8, r16;
        delay8 = 1; delay16 = 1;
        r8 = rise8; r16 = rise16;
        request(27'h10, 1, 1);
        wait_done();
        checks++; if (dur8_last !== 2) begin errors++; $display("FAIL lat8_min: got %0d expected 2", dur8_last); end
        checks++; if (rd_addr8 !== 16'h0010) begin errors++; $display("FAIL addr8: got %h expected 0010", rd_addr8); end
        checks++; if (rise8 !== r8 + 1) begin errors++; $display("FAIL rd8_count: got %0d expected %0d", rise8 - r8, 1); end
        checks++; if (dur16_last !== 5) begin errors++; $display("FAIL lat16_min: got %0d expected 5", dur16_last); end
    endtask

    task automatic test_wide();
        int r16;
        delay8 = 3; delay16 = 3;
        r16 = rise16;
        request(27'h20, 1, 1);
        wait_done();
        checks++; if (rise16 !== r16 + 2) begin errors++; $display("FAIL rd16_count: got %0d expected 2", rise16 - r16); end
        checks++; if (gap16_last !== 1) begin errors++; $display("FAIL rd16_gap: got %0d expected 1", gap16_last); end
        checks++; if (rd_addr16 !== 16'h0021) begin errors++; $display("FAIL addr16_hi: got %h expected 0021", rd_addr16); end
        checks++; if (dur16_last !== 9) begin errors++; $display("FAIL lat16_d3: got %0d expected 9", dur16_last); end
        checks++; if (dur8_last !== 4) begin errors++; $display("FAIL lat8_d3: got %0d expected 4", dur8_last); end
    endtask

    task automatic test_range();
        int r8, r16;
        delay8 = 1; delay16 = 1;
        r8 = rise8; r16 = rise16;
        request(27'h100, 1, 1);
        wait_done();
        checks++; if (dur8_last !== 1) begin errors++; $display("FAIL oor_wait8: got %0d expected 1", dur8_last); end
        request(27'h100FE, 1, 1);
        wait_done();
        checks++; if ({rise8, rise16} !== {r8, r16}) begin
            errors++; $display("FAIL oor_no_rd: got %0d/%0d strobes expected 0/0", rise8 - r8, rise16 - r16); end
        request(27'hFE, 1, 1);
        wait_done();
        checks++; if (rise16 !== r16 + 1) begin errors++; $display("FAIL half_oor_rd16: got %0d expected 1", rise16 - r16); end
    endtask

    task automatic test_abort();
        logic [7:0]  d8;
        logic [15:0] d16;
        delay8 = 3; delay16 = 3;
        d8 = din8; d16 = din16;
        request(27'h30, 0, 0);
        exp8_q.push_back(d8);
        exp16_q.push_back(d16);
        tick();
        ioctl_upload = 1'b0;
        tick();
        checks++; if ({rd8, rd16, wait8, wait16} !== 4'b0) begin
            errors++; $display("FAIL abort_ctrl: got %b expected 0000", {rd8, rd16, wait8, wait16}); end
        checks++; if ({sel8, sel16} !== 2'b00) begin errors++; $display("FAIL sel_fall: got %b expected 00", {sel8, sel16}); end
        wait_done();
        ioctl_upload = 1'b1;
        tick(); tick();
    endtask

    task automatic test_ignore();
        int r8, r16;
        logic [7:0]  d8;
        logic [15:0] d16;
        r8 = rise8; r16 = rise16; d8 = din8; d16 = din16;
        ioctl_index = 8'd3;
        tick(); tick();
        request(27'h10, 0, 0);
        repeat (4) tick();
        checks++; if ({sel8, sel16, wait8, wait16} !== 4'b0) begin
            errors++; $display("FAIL idx_ctrl: got %b expected 0000", {sel8, sel16, wait8, wait16}); end
        checks++; if ({din8, din16} !== {d8, d16}) begin
            errors++; $display("FAIL idx_din: got %h/%h expected %h/%h", din8, din16, d8, d16); end
        checks++; if ({rise8, rise16} !== {r8, r16}) begin
            errors++; $display("FAIL idx_no_rd: got %0d/%0d strobes expected 0/0", rise8 - r8, rise16 - r16); end
        ioctl_index = 8'd2;
        tick(); tick();
        delay8 = 3; delay16 = 3;
        request(27'h40, 1, 1);
        ioctl_addr = 27'h50;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd   = 1'b0;
        wait_done();
        checks++; if ({rise8, rise16} !== {r8 + 1, r16 + 2}) begin
            errors++; $display("FAIL busy_rd: got %0d/%0d strobes expected 1/2", rise8 - r8, rise16 - r16); end
    endtask

    task automatic test_reset_mid();
        int r16, n;
        delay8 = 3; delay16 = 3;
        r16 = rise16;
        request(27'h20, 1, 0);
        n = 0;
        while (rise16 < r16 + 2 && n < 50) begin tick(); n++; end
        checks++; if (rise16 < r16 + 2) begin errors++; $display("FAIL hi_fetch_start: got %0d strobes expected 2", rise16 - r16); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({wait16, rd16, sel16} !== 3'b0) begin
            errors++; $display("FAIL async_rst_ctrl: got %b expected 000", {wait16, rd16, sel16}); end
        checks++; if ({din16, addr16} !== 32'h0) begin
            errors++; $display("FAIL async_rst_data: got %h/%h expected 0/0", din16, addr16); end
        exp16_q.push_back(16'h0000);
        tick();
        rst = 1'b0;
        tick();
        delay8 = 2; delay16 = 2;
        request(27'h21, 1, 1);
        wait_done();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem8[i]  = 8'(i * 7 + 3);
            mem16[i] = 8'(i * 7 + 3);
        end
        mem8[8'h10]  = 8'h5A;
        mem16[8'h10] = 8'h5A;
        mem16[8'h20] = 8'h12;
        mem16[8'h21] = 8'h34;
        mem8[8'h20]  = 8'h12;
        mem8[8'h21]  = 8'h34;
        test_reset();
        test_byte8();
        test_wide();
        test_range();
        test_abort();
        test_ignore();
        test_reset_mid();
        checks++;
        if (moved8 || moved16) begin
            errors++; $display("FAIL addr_stable: got moved=%b/%b expected 0/0", moved8, moved16);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jtframe_mr_upload.md
# jtframe_mr_upload

Serves MiSTer HPS upload requests (ioctl_upload/ioctl_rd from hps_io) by fetching bytes from a core-side memory port, such as NVRAM or high-score RAM, and presenting them on ioctl_din. It is the read-back counterpart of the download path, and sits between hps_io and the core memory mux in the MiSTer top level. It supports the 8-bit and the 16-bit (WIDE) hps_io modes. In WIDE mode it packs two byte reads into one word, with the even byte in bits [7:0].

## Interface
- WIDE, 0: 1 selects a 16-bit ioctl_din and two byte fetches per request; 0 selects 8-bit.
- AW, 16: core memory byte-address width.
- SIZE, 65536: number of valid bytes. Addresses at or above SIZE read as 8'hFF.
- UPLOAD_INDEX, 8'd2: ioctl_index value this block responds to.

Ports (clock and reset first):
- clk_sys  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- ioctl_upload  in  1  upload session active (from hps_io).
- ioctl_index  in  8  file index of the session.
- ioctl_rd  in  1  one-cycle read request.
- ioctl_addr  in  27  byte address of the request; even when WIDE=1.
- ioctl_din  out  WIDE?16:8  read data returned to hps_io.
- ioctl_wait  out  1  high while a fetch is in progress.
- mem_sel  out  1  claims the core memory port; the core mux gives priority when high.
- mem_addr  out  AW  byte address to core memory.
- mem_rd  out  1  read strobe, held until mem_ok.
- mem_dout  in  8  core memory data; valid while mem_ok=1.
- mem_ok  in  1  read acknowledge; earliest one cycle after mem_rd rises.

## Operation
- The block is active when ioctl_upload=1 and ioctl_index==UPLOAD_INDEX. mem_sel is the registered value of this condition.
- FSM states:
  - IDLE: waits for a request.
  - FETCH_LO: reads the byte at ioctl_addr.
  - FETCH_HI (WIDE only): reads the byte at ioctl_addr+1.
  - GAP: one idle cycle with mem_rd=0 between the two WIDE fetches.
- IDLE → FETCH_LO on ioctl_rd while active. The address is latched from ioctl_addr[AW-1:0]; mem_rd=1 and ioctl_wait=1 are set.
- FETCH_LO on mem_ok:
  - mem_dout is latched into the low byte and mem_rd drops.
  - If WIDE=0: ioctl_din is updated, ioctl_wait=0, and the FSM returns to IDLE.
  - If WIDE=1: → GAP → FETCH_HI with mem_addr+1.
- FETCH_HI on mem_ok: the high byte is latched, ioctl_din={hi,lo} is updated, ioctl_wait=0, and the FSM returns to IDLE.
- Out-of-range bytes (full 27-bit address ≥ SIZE): the byte is 8'hFF, mem_rd is never asserted, and the state completes in one cycle.
- In WIDE mode, if only the high byte is out of range, it reads 8'hFF and the low byte is fetched normally.
- ioctl_rd while not in IDLE is ignored.
- ioctl_rd while inactive is ignored, and ioctl_din is unchanged.
- ioctl_upload falling or ioctl_index changing mid-fetch: abort to IDLE, with mem_rd=0 and ioctl_wait=0 on the next edge, and ioctl_din unchanged.
- ioctl_din holds its value between requests.

## Timing
- Reset values: ioctl_din=0, ioctl_wait=0, mem_sel=0, mem_addr=0, mem_rd=0, state IDLE.
- All outputs are registered.
- ioctl_rd sampled at edge 0 → ioctl_wait and mem_rd high after edge 1.
- mem_ok high at edge N → ioctl_din valid and ioctl_wait low after edge N (8-bit mode).
- Minimum 8-bit latency: 2 cycles from ioctl_rd to ioctl_wait falling.
- Minimum WIDE latency: 2 + 1 (GAP) + 2 = 5 cycles.
- Out-of-range request in 8-bit mode: ioctl_wait is high for exactly 1 cycle.
- mem_addr is stable for the whole time mem_rd is high.
- mem_sel asserts 1 cycle after the active condition rises and drops 1 cycle after it falls.
- An asynchronous rst mid-fetch clears everything immediately; no memory write is ever issued.

## Structure
- A shared package jtframe_mr_pkg holds:
  - the state typedef (IDLE, FETCH_LO, GAP, FETCH_HI);
  - the default UPLOAD_INDEX constant;
  - the out-of-range fill value 8'hFF.
- One sub-module is natural: jtframe_mr_bytefetch. It is the single-byte mem_rd/mem_ok handshake with range check, and is instantiated once and reused for both bytes by the FSM.

## Test plan
- WIDE=0, memory has 8'h5A at 16'h0010, mem_ok 1 cycle after mem_rd; ioctl_rd at addr 'h10 → mem_addr=16'h0010, ioctl_din=8'h5A, ioctl_wait high exactly 2 cycles.
- WIDE=1, memory has 'h12 at 'h20 and 'h34 at 'h21, mem_ok delay 3 cycles → two mem_rd pulses with one low cycle between them, ioctl_din=16'h3412, ioctl_wait falls after the second mem_ok.
- SIZE=16'h0100, ioctl_rd at addr 'h0100 → no mem_rd, ioctl_din=8'hFF; with WIDE=1 at addr 'h00FF-1='h00FE and SIZE='hFF → ioctl_din={8'hFF, mem['hFE]}.
- ioctl_upload drops 2 cycles into a fetch → mem_rd and ioctl_wait are 0 on the next edge, state is IDLE, and ioctl_din keeps its previous value.
- ioctl_index=8'd3, or ioctl_rd pulsed while ioctl_wait=1 → no memory activity, mem_sel stays 0 (index mismatch case), and outputs are unchanged.
- rst asserted mid-FETCH_HI → all outputs return to their reset values asynchronously, and a new request after release completes normally.
